// File: rtl/spi_cmd_deserializer_fifo_if.sv
// spi_cmd_deserializer_fifo_if: frame handshake and decoded head-of-FIFO fields
interface spi_cmd_deserializer_fifo_if #(
    parameter int ADDRW = 8,
    parameter int OPCODEW = 2
);
    logic ready_in;
    logic valid_out;
    logic valid;
    logic [OPCODEW-1:0] opcode;
    logic [ADDRW-1:0] key_addr;
    logic [ADDRW-1:0] text_addr;
    logic [ADDRW-1:0] dest_addr;
    modport master(input ready_in, output valid_out, valid, opcode, key_addr, text_addr, dest_addr);
    modport slave(output ready_in, input valid_out, valid, opcode, key_addr, text_addr, dest_addr);
endinterface

// File: rtl/spi_cmd_deserializer_fifo.sv
// spi_cmd_deserializer_fifo: oversampled SPI slave assembling command frames into a show-ahead FIFO
module spi_cmd_deserializer_fifo #(
    parameter int ADDRW = 8,
    parameter int OPCODEW = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNTW = 8,
    localparam int SHIFT_W = 1 + OPCODEW + 3*ADDRW,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int LW = PW + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    input  logic mosi,
    input  logic cs_n,
    spi_cmd_deserializer_fifo_if.master frm,
    output logic [LW-1:0] fifo_level,
    output logic overflow,
    output logic frame_err,
    output logic [CNTW-1:0] drop_cnt,
    output logic [CNTW-1:0] err_cnt
);
    localparam int CW = $clog2(SHIFT_W + 2);
    localparam logic [CW-1:0] FULL = CW'(SHIFT_W);
    localparam logic [CW-1:0] SAT = CW'(SHIFT_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, csn_sr;
    logic sclk_d, sclk_dd, mosi_d, csn_d, csn_dd;
    logic [SYNC_STAGES+1:0] warm;
    logic sclk_rise, csn_rise, csn_fall, armed;
    state_t state, state_nx;
    logic [SHIFT_W-1:0] shreg;
    logic [CW-1:0] cnt;
    logic push, pop, drop, bad, can_accept;
    logic [SHIFT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [SHIFT_W-1:0] head;

    // An extra delay stage after the synchronizers registers the edge detect; warm masks a cs_n held low across reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sr <= '0;
            mosi_sr <= '0;
            csn_sr <= '1;
            {sclk_d, sclk_dd, mosi_d} <= '0;
            {csn_d, csn_dd} <= '1;
            warm <= '0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_clk};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            csn_sr <= {csn_sr[SYNC_STAGES-2:0], cs_n};
            sclk_d <= sclk_sr[SYNC_STAGES-1];
            sclk_dd <= sclk_d;
            mosi_d <= mosi_sr[SYNC_STAGES-1];
            csn_d <= csn_sr[SYNC_STAGES-1];
            csn_dd <= csn_d;
            warm <= {warm[SYNC_STAGES:0], 1'b1};
        end
    end

    assign sclk_rise = sclk_d & ~sclk_dd;
    assign csn_rise = csn_d & ~csn_dd;
    assign csn_fall = ~csn_d & csn_dd;
    assign armed = warm[SYNC_STAGES+1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        push = 1'b0;
        drop = 1'b0;
        bad = 1'b0;
        case (state)
            IDLE: state_nx = (csn_fall && armed) ? SHIFT : IDLE;
            SHIFT: state_nx = csn_rise ? COMMIT : SHIFT;
            default: begin
                state_nx = IDLE;
                push = (cnt == FULL) && can_accept;
                drop = (cnt == FULL) && !can_accept;
                bad = (cnt != FULL) && (cnt != '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && state_nx == SHIFT)) begin
            shreg <= '0;
            cnt <= '0;
        end else if (state == SHIFT && sclk_rise) begin
            shreg <= {shreg[SHIFT_W-2:0], mosi_d};
            cnt <= (cnt == SAT) ? cnt : cnt + 1'b1;
        end
    end

    assign pop = frm.valid_out && frm.ready_in;
    assign can_accept = (fifo_level < LW'(FIFO_DEPTH)) || pop;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            fifo_level <= '0;
            overflow <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt <= '0;
            err_cnt <= '0;
        end else begin
            wp <= wp + PW'(push);
            rp <= rp + PW'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            overflow <= drop;
            frame_err <= bad;
            drop_cnt <= drop_cnt + CNTW'(drop && drop_cnt != '1);
            err_cnt <= err_cnt + CNTW'(bad && err_cnt != '1);
        end
    end

    assign frm.valid_out = fifo_level != '0;
    assign head = frm.valid_out ? mem[rp] : '0;
    assign frm.valid = head[SHIFT_W-1];
    assign frm.opcode = head[SHIFT_W-2 -: OPCODEW];
    assign frm.key_addr = head[3*ADDRW-1 -: ADDRW];
    assign frm.text_addr = head[2*ADDRW-1 -: ADDRW];
    assign frm.dest_addr = head[ADDRW-1:0];
endmodule

// File: tb/tb_spi_cmd_deserializer_fifo.sv
// tb_spi_cmd_deserializer_fifo: directed and random frames checked through a scoreboard queue
module tb_spi_cmd_deserializer_fifo;
    localparam int S = 2;
    localparam int H = 6;

    logic clk = 0;
    logic rst = 1;
    logic spi_clk = 0;
    logic mosi = 0;
    logic cs_n = 1;
    logic ready_in = 1;
    logic [2:0] fifo_level;
    logic overflow, frame_err;
    logic [7:0] drop_cnt, err_cnt;
    logic [26:0] exp_q[$];
    logic [26:0] head, e;
    logic [31:0] tab[5];
    int n_cmp = 0, n_fail = 0, n_pops = 0, ovf_seen = 0, ferr_seen = 0;
    int p0, f0;
    bit done;

    spi_cmd_deserializer_fifo_if bus();
    assign bus.ready_in = ready_in;
    assign head = {bus.valid, bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr};

    spi_cmd_deserializer_fifo dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n),
        .frm(bus), .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovf_seen++;
            if (frame_err) ferr_seen++;
            if (bus.valid_out && bus.ready_in) begin
                n_pops++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got %h, required no frame", head);
                end else begin
                    e = exp_q.pop_front();
                    if (head !== e) begin
                        n_fail++;
                        $display("FAIL pop_frame: got %h, required %h", head, e);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic v, input logic [1:0] op, input logic [7:0] k, t, d);
        return {5'b0, v, op, k, t, d};
    endfunction

    task automatic bit_clk(input logic b);
        mosi = b;
        cyc(H);
        spi_clk = 1;
        cyc(H);
        spi_clk = 0;
    endtask

    task automatic spi_frame(input logic [31:0] w, input int n);
        cs_n = 0;
        cyc(H);
        for (int i = n - 1; i >= 0; i--) bit_clk(w[i]);
        cyc(H);
        cs_n = 1;
    endtask

    task automatic send(input logic [31:0] w, input int n, input bit exp);
        if (exp) exp_q.push_back(w[26:0]);
        spi_frame(w, n);
        cyc(H + 4);
    endtask

    initial begin
        logic [31:0] f1, f2, w;
        f1 = mk(1'b1, 2'b01, 8'hAA, 8'h55, 8'h0E);
        f2 = mk(1'b1, 2'b10, 8'h0F, 8'hF0, 8'h7C);
        cyc(5);
        chk("rst_valid_out", int'(bus.valid_out), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_pulses", int'({overflow, frame_err}), 0);
        chk("rst_counters", int'({drop_cnt, err_cnt}), 0);
        chk("rst_fields", int'(head), 0);
        rst = 0;
        cyc(10);

        // Single frame, latency and one-shot valid_out
        exp_q.push_back(f1[26:0]);
        spi_frame(f1, 27);
        cyc(S + 2);
        chk("latency_early", int'(bus.valid_out), 0);
        cyc(1);
        chk("latency_rise", int'(bus.valid_out), 1);
        cyc(1);
        chk("one_shot", int'(bus.valid_out), 0);
        chk("level_drained", int'(fifo_level), 0);
        chk("pops_t1", n_pops, 1);
        cyc(H);

        // Short frame then good frame
        send(f2 >> 14, 13, 0);
        chk("short_ferr", ferr_seen, 1);
        chk("short_err_cnt", int'(err_cnt), 1);
        chk("short_no_pop", n_pops, 1);
        send(f2, 27, 1);
        chk("good_after_short", n_pops, 2);

        // Overflow under backpressure
        ready_in = 0;
        tab[0] = mk(1'b1, 2'd0, 8'h01, 8'h02, 8'h03);
        tab[1] = mk(1'b0, 2'd1, 8'h11, 8'h12, 8'h13);
        tab[2] = mk(1'b1, 2'd2, 8'h21, 8'h22, 8'h23);
        tab[3] = mk(1'b1, 2'd3, 8'h31, 8'h32, 8'h33);
        tab[4] = mk(1'b1, 2'd1, 8'h41, 8'h42, 8'h43);
        for (int i = 0; i < 5; i++) send(tab[i], 27, i < 4);
        chk("full_level", int'(fifo_level), 4);
        chk("ovf_pulse", ovf_seen, 1);
        chk("drop_cnt", int'(drop_cnt), 1);
        chk("head_key", int'(bus.key_addr), 8'h01);
        cyc(5);
        chk("head_stable", int'(head), int'(tab[0][26:0]));
        ready_in = 1;
        cyc(10);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_level0", int'(fifo_level), 0);

        // 28-bit frame and empty select
        send({f1[26:0], 1'b1}, 28, 0);
        chk("long_ferr", ferr_seen, 2);
        chk("long_err_cnt", int'(err_cnt), 2);
        p0 = n_pops;
        cs_n = 0;
        cyc(H);
        cs_n = 1;
        cyc(H + 4);
        chk("empty_sel_err", int'(err_cnt), 2);
        chk("empty_sel_pop", n_pops, p0);

        // Frame completing on the pop cycle while full
        ready_in = 0;
        for (int i = 0; i < 4; i++) send(mk(1'(i), 2'(i), 8'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i)), 27, 1);
        w = mk(1'b1, 2'b11, 8'hC5, 8'h5C, 8'h99);
        exp_q.push_back(w[26:0]);
        spi_frame(w, 27);
        cyc(S + 2);
        chk("pre_pop_level", int'(fifo_level), 4);
        ready_in = 1;
        cyc(1);
        chk("push_pop_level", int'(fifo_level), 4);
        chk("push_pop_no_ovf", ovf_seen, 1);
        cyc(10);
        chk("push_pop_drained", exp_q.size(), 0);
        chk("push_pop_drop_cnt", int'(drop_cnt), 1);

        // Reset mid-frame discards it; cs_n low at release does not start a frame
        p0 = n_pops;
        f0 = ferr_seen;
        cs_n = 0;
        cyc(H);
        for (int i = 0; i < 10; i++) bit_clk(f1[26 - i]);
        rst = 1;
        cyc(3);
        rst = 0;
        for (int i = 10; i < 27; i++) bit_clk(f1[26 - i]);
        cyc(H);
        cs_n = 1;
        cyc(H + 4);
        chk("midrst_level", int'(fifo_level), 0);
        chk("midrst_counters", int'({drop_cnt, err_cnt}), 0);
        chk("midrst_no_pop", n_pops, p0);
        chk("midrst_no_ferr", ferr_seen, f0);

        // Random frames with random ready_in
        done = 0;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(mk(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 27, 1);
                done = 1;
            end
            begin
                while (!done) begin
                    ready_in = 1'($urandom_range(0, 1));
                    cyc(1);
                end
            end
        join
        ready_in = 1;
        cyc(10);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_pops", n_pops, p0 + 16);
        chk("rand_drop_cnt", int'(drop_cnt), 0);
        chk("rand_err_cnt", int'(err_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
